hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//   Hazard controller for the 5-stage pipeline. Sequences the D/E pipeline register and the front end.
//   - Compares D-stage register use (Tuse) against E/M producer readiness (Tnew).
//   - Issues the stall: freeze PC and F/D, clear D/E.
//   - Drives the D and E forwarding-mux selects.
//   - Owns the multi-cycle mult/div busy counter and a stall performance counter.
// PARAMETERS
//   MULT_CYC  5   busy cycles after a mult/multu starts in E
//   DIV_CYC   10  busy cycles after a div/divu starts in E
//   CNT_W     4   busy-counter width; MULT_CYC and DIV_CYC must be < 2**CNT_W
// PORTS
//   clk           in   1   clock, rising edge
//   reset         in   1   asynchronous, active-high reset
//   D_A1, D_A2    in   5   rs/rt of the instruction in D
//   D_A1use       in   1   D instruction reads rs
//   D_A2use       in   1   D instruction reads rt
//   D_Tuse_rs     in   2   cycles until D needs rs (0 = needs it in D)
//   D_Tuse_rt     in   2   same, for rt
//   D_is_md       in   1   D instruction is mult/div/mfhi/mflo/mthi/mtlo
//   E_A1, E_A2    in   5   rs/rt of the instruction in E
//   E_A3          in   5   destination register in E
//   E_Reg_Write   in   1   E instruction writes the GRF
//   E_Tnew        in   4   cycles until the E result is ready
//   E_md_start    in   1   E holds mult/multu/div/divu (one-cycle pulse)
//   E_md_div      in   1   with E_md_start: 1 = div class, 0 = mult class
//   M_A3          in   5   destination register in M
//   M_Reg_Write   in   1   M instruction writes the GRF
//   M_Tnew        in   4   cycles until the M result is ready
//   W_A3          in   5   destination register in W
//   W_Reg_Write   in   1   W instruction writes the GRF
//   PC_en         out  1   PC write enable (0 = stall)
//   F_D_en        out  1   F/D write enable (0 = stall)
//   D_E_clear     out  1   flush D/E, inserting a bubble
//   D_fwd_rs      out  2   D-stage rs mux: 0 GRF, 2 M, 3 E
//   D_fwd_rt      out  2   D-stage rt mux, same encoding
//   E_fwd_rs      out  2   E-stage rs mux: 0 D/E value, 1 W, 2 M
//   E_fwd_rt      out  2   E-stage rt mux, same encoding
//   md_busy       out  1   mult/div unit is occupied
//   stall_cnt     out  32  saturating count of stall cycles
// BEHAVIOUR
//   Match condition:
//     match(A, S) = S_Reg_Write && S_A3 == A && A != 0
//   Data stall: raised for rs if D_A1use and either
//     match(D_A1, E) && E_Tnew > D_Tuse_rs, or
//     match(D_A1, M) && M_Tnew > D_Tuse_rs.
//     rt uses the same rule with D_A2use, D_A2 and D_Tuse_rt.
//   MD stall:
//     md_stall = D_is_md && md_busy
//   stall = data_stall || md_stall. All combinational, valid in the same cycle.
//   Stall outputs:
//     PC_en  = ~stall
//     F_D_en = ~stall
//     D_E_clear = stall
//   D forwarding (nearest stage wins):
//     3 if match(A, E) && E_Tnew == 0
//     else 2 if match(A, M) && M_Tnew == 0
//     else 0
//   E forwarding, using E_A1/E_A2:
//     2 if match(A, M) && M_Tnew == 0
//     else 1 if match(A, W)
//     else 0
//   Register 0 never forwards and never stalls.
//   Busy counter md_cnt[CNT_W-1:0]:
//     - E_md_start && md_cnt == 0: load DIV_CYC if E_md_div, else MULT_CYC.
//     - Otherwise, if md_cnt != 0: decrement by 1.
//     - E_md_start while md_cnt != 0: ignored, counter keeps decrementing. Cannot occur in legal flow, because md_stall blocks it.
//     - md_busy = E_md_start || (md_cnt != 0). The start cycle already counts as busy.
//     - A mult started at edge t leaves md_busy high for 1 + MULT_CYC cycles, i.e. 6 at the defaults.
//   stall_cnt:
//     - Increments by 1 on each rising edge where stall = 1.
//     - Holds at 32'hFFFF_FFFF; never wraps.
//   Reset (asynchronous, any time, including mid mult/div):
//     - md_cnt = 0 and stall_cnt = 0 immediately.
//     - With D/E inputs at 0: md_busy = 0, PC_en = 1, F_D_en = 1, D_E_clear = 0, all fwd selects = 0.
// TESTING
//   1. lw $1 in E (E_Tnew=1), D addu reads $1 with Tuse=1 -> no stall. Next cycle M_Tnew=0, D_fwd=0, E_fwd_rs=2.
//   2. lw $1 in E (E_Tnew=1), D beq reads $1 with Tuse=0 -> stall: PC_en=0, F_D_en=0, D_E_clear=1 for 1 cycle, then D_fwd_rs=2.
//   3. Matching writes to $0 from E, M and W -> no stall, all fwd selects 0.
//   4. E_md_start=1 with E_md_div=1, then D_is_md=1 -> md_busy high 11 cycles, stall throughout, stall_cnt +11.
//   5. Assert reset mid-div with md_cnt=7 -> md_busy=0 and stall_cnt=0 immediately, before the next clk edge.
//   6. Force stall_cnt=32'hFFFF_FFFE and stall 3 cycles -> stall_cnt holds at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Hazard controller for the 5-stage pipeline: Tuse/Tnew stall detection, forwarding selects,
// mult/div busy tracking and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_A1,
  input  logic [4:0]  D_A2,
  input  logic        D_A1use,
  input  logic        D_A2use,
  input  logic [1:0]  D_Tuse_rs,
  input  logic [1:0]  D_Tuse_rt,
  input  logic        D_is_md,
  input  logic [4:0]  E_A1,
  input  logic [4:0]  E_A2,
  input  logic [4:0]  E_A3,
  input  logic        E_Reg_Write,
  input  logic [3:0]  E_Tnew,
  input  logic        E_md_start,
  input  logic        E_md_div,
  input  logic [4:0]  M_A3,
  input  logic        M_Reg_Write,
  input  logic [3:0]  M_Tnew,
  input  logic [4:0]  W_A3,
  input  logic        W_Reg_Write,
  output logic        PC_en,
  output logic        F_D_en,
  output logic        D_E_clear,
  output logic [1:0]  D_fwd_rs,
  output logic [1:0]  D_fwd_rt,
  output logic [1:0]  E_fwd_rs,
  output logic [1:0]  E_fwd_rt,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC);
  localparam logic [31:0]      CNT_MAX = 32'hFFFF_FFFF;

  logic [CNT_W-1:0] md_cnt;
  logic             rs_stall;
  logic             rt_stall;
  logic             md_stall;
  logic             stall;

  // A producer matches only when it writes a non-zero register equal to the consumer's.
  function automatic logic match(input logic [4:0] a, input logic wr, input logic [4:0] a3);
    return wr && (a3 == a) && (a != 5'd0);
  endfunction

  function automatic logic data_hazard(input logic use_a, input logic [4:0] a,
                                       input logic [1:0] tuse);
    return use_a &&
           ((match(a, E_Reg_Write, E_A3) && (E_Tnew > 4'(tuse))) ||
            (match(a, M_Reg_Write, M_A3) && (M_Tnew > 4'(tuse))));
  endfunction

  function automatic logic [1:0] d_sel(input logic [4:0] a);
    if (match(a, E_Reg_Write, E_A3) && (E_Tnew == 4'd0)) return 2'd3;
    if (match(a, M_Reg_Write, M_A3) && (M_Tnew == 4'd0)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [1:0] e_sel(input logic [4:0] a);
    if (match(a, M_Reg_Write, M_A3) && (M_Tnew == 4'd0)) return 2'd2;
    if (match(a, W_Reg_Write, W_A3)) return 2'd1;
    return 2'd0;
  endfunction

  // Stall decision and forwarding selects, all valid in the same cycle.
  always_comb begin
    rs_stall  = 1'b0;
    rt_stall  = 1'b0;
    md_busy   = 1'b0;
    md_stall  = 1'b0;
    stall     = 1'b0;
    PC_en     = 1'b1;
    F_D_en    = 1'b1;
    D_E_clear = 1'b0;
    D_fwd_rs  = 2'd0;
    D_fwd_rt  = 2'd0;
    E_fwd_rs  = 2'd0;
    E_fwd_rt  = 2'd0;

    rs_stall  = data_hazard(D_A1use, D_A1, D_Tuse_rs);
    rt_stall  = data_hazard(D_A2use, D_A2, D_Tuse_rt);
    md_busy   = E_md_start || (md_cnt != '0);
    md_stall  = D_is_md && md_busy;
    stall     = rs_stall || rt_stall || md_stall;

    PC_en     = ~stall;
    F_D_en    = ~stall;
    D_E_clear = stall;
    D_fwd_rs  = d_sel(D_A1);
    D_fwd_rt  = d_sel(D_A2);
    E_fwd_rs  = e_sel(E_A1);
    E_fwd_rt  = e_sel(E_A2);
  end

  // Busy counter; a start while already counting is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (E_md_start && (md_cnt == '0)) begin
      md_cnt <= E_md_div ? DIV_LD : MULT_LD;
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CNT_W'(1);
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 32'd0;
    end else if (stall && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed pipeline scenarios plus randomized
// vectors checked against a cycle-count based reference model.
module tb_hazard_stall_ctrl;

  localparam int unsigned MULT_CYC = 5;
  localparam int unsigned DIV_CYC  = 10;

  logic        clk;
  logic        reset;
  logic [4:0]  D_A1, D_A2, E_A1, E_A2, E_A3, M_A3, W_A3;
  logic        D_A1use, D_A2use, D_is_md;
  logic [1:0]  D_Tuse_rs, D_Tuse_rt;
  logic        E_Reg_Write, M_Reg_Write, W_Reg_Write;
  logic [3:0]  E_Tnew, M_Tnew;
  logic        E_md_start, E_md_div;
  logic        PC_en, F_D_en, D_E_clear, md_busy;
  logic [1:0]  D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt;
  logic [31:0] stall_cnt;
  logic [11:0] outs;

  int          vecs;
  int          errs;
  int unsigned cyc;
  int unsigned md_end;
  logic [31:0] exp_cnt;

  hazard_stall_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .D_A1(D_A1), .D_A2(D_A2), .D_A1use(D_A1use), .D_A2use(D_A2use),
    .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt), .D_is_md(D_is_md),
    .E_A1(E_A1), .E_A2(E_A2), .E_A3(E_A3), .E_Reg_Write(E_Reg_Write), .E_Tnew(E_Tnew),
    .E_md_start(E_md_start), .E_md_div(E_md_div),
    .M_A3(M_A3), .M_Reg_Write(M_Reg_Write), .M_Tnew(M_Tnew),
    .W_A3(W_A3), .W_Reg_Write(W_Reg_Write),
    .PC_en(PC_en), .F_D_en(F_D_en), .D_E_clear(D_E_clear),
    .D_fwd_rs(D_fwd_rs), .D_fwd_rt(D_fwd_rt), .E_fwd_rs(E_fwd_rs), .E_fwd_rt(E_fwd_rt),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  assign outs = {PC_en, F_D_en, D_E_clear, D_fwd_rs, D_fwd_rt, E_fwd_rs, E_fwd_rt, md_busy};

  always #5 clk = ~clk;

  // Reference model: the mult/div unit is busy while the cycle index is below md_end.
  function automatic logic mt(input logic [4:0] a, input logic wr, input logic [4:0] a3);
    return wr && (a3 == a) && (a != 5'd0);
  endfunction

  function automatic logic m_busy();
    return E_md_start || (cyc < md_end);
  endfunction

  function automatic logic m_hz(input logic u, input logic [4:0] a, input logic [1:0] tuse);
    int t;
    t = int'(tuse);
    return u && ((mt(a, E_Reg_Write, E_A3) && int'(E_Tnew) > t) ||
                 (mt(a, M_Reg_Write, M_A3) && int'(M_Tnew) > t));
  endfunction

  function automatic logic m_stall();
    return m_hz(D_A1use, D_A1, D_Tuse_rs) || m_hz(D_A2use, D_A2, D_Tuse_rt) ||
           (D_is_md && m_busy());
  endfunction

  function automatic logic [1:0] m_dfwd(input logic [4:0] a);
    if (mt(a, E_Reg_Write, E_A3) && E_Tnew == 4'd0) return 2'd3;
    else if (mt(a, M_Reg_Write, M_A3) && M_Tnew == 4'd0) return 2'd2;
    else return 2'd0;
  endfunction

  function automatic logic [1:0] m_efwd(input logic [4:0] a);
    if (mt(a, M_Reg_Write, M_A3) && M_Tnew == 4'd0) return 2'd2;
    else if (mt(a, W_Reg_Write, W_A3)) return 2'd1;
    else return 2'd0;
  endfunction

  function automatic logic [11:0] m_outs();
    logic s;
    s = m_stall();
    return {~s, ~s, s, m_dfwd(D_A1), m_dfwd(D_A2), m_efwd(E_A1), m_efwd(E_A2), m_busy()};
  endfunction

  task automatic clear_inputs();
    {D_A1, D_A2, E_A1, E_A2, E_A3, M_A3, W_A3} = '0;
    {D_A1use, D_A2use, D_is_md, E_Reg_Write, M_Reg_Write, W_Reg_Write} = '0;
    D_Tuse_rs = 2'd0; D_Tuse_rt = 2'd0; E_Tnew = 4'd0; M_Tnew = 4'd0;
    E_md_start = 1'b0; E_md_div = 1'b0;
  endtask

  // Advance one clock edge and update the model with what the edge consumed.
  task automatic tick();
    logic s, go, dv;
    s  = m_stall();
    go = E_md_start && (cyc >= md_end);
    dv = E_md_div;
    @(posedge clk);
    if (reset) begin
      exp_cnt = 32'd0;
      md_end  = cyc + 1;
    end else begin
      if (s && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
      if (go) md_end = cyc + 1 + (dv ? DIV_CYC : MULT_CYC);
    end
    cyc = cyc + 1;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    #1;
    vecs++;
    if (outs !== 12'b1_1_0_00_00_00_00_0) begin
      errs++; $display("FAIL reset_outs got %b want %b", outs, 12'b1_1_0_00_00_00_00_0);
    end
    vecs++;
    if (stall_cnt !== 32'd0) begin
      errs++; $display("FAIL reset_cnt got %h want 0", stall_cnt);
    end
    tick();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_lw_use_no_stall();
    @(negedge clk);
    clear_inputs();
    E_A3 = 5'd1; E_Reg_Write = 1'b1; E_Tnew = 4'd1;
    D_A1 = 5'd1; D_A1use = 1'b1; D_Tuse_rs = 2'd1;
    #1;
    vecs++;
    if (outs !== 12'b1_1_0_00_00_00_00_0) begin
      errs++; $display("FAIL lw_tuse1_d got %b want %b", outs, 12'b1_1_0_00_00_00_00_0);
    end
    tick();
    @(negedge clk);
    clear_inputs();
    M_A3 = 5'd1; M_Reg_Write = 1'b1; M_Tnew = 4'd0;
    E_A1 = 5'd1; E_A3 = 5'd2; E_Reg_Write = 1'b1; E_Tnew = 4'd1;
    #1;
    vecs++;
    if (outs !== 12'b1_1_0_00_00_10_00_0) begin
      errs++; $display("FAIL lw_tuse1_e got %b want %b", outs, 12'b1_1_0_00_00_10_00_0);
    end
    tick();
    vecs++;
    if (stall_cnt !== exp_cnt || exp_cnt !== 32'd0) begin
      errs++; $display("FAIL lw_tuse1_cnt got %h want 0", stall_cnt);
    end
  endtask

  task automatic test_lw_branch_stall();
    @(negedge clk);
    clear_inputs();
    E_A3 = 5'd1; E_Reg_Write = 1'b1; E_Tnew = 4'd1;
    D_A1 = 5'd1; D_A1use = 1'b1; D_Tuse_rs = 2'd0;
    #1;
    vecs++;
    if (outs !== 12'b0_0_1_00_00_00_00_0) begin
      errs++; $display("FAIL lw_beq_stall got %b want %b", outs, 12'b0_0_1_00_00_00_00_0);
    end
    tick();
    vecs++;
    if (stall_cnt !== 32'd1) begin
      errs++; $display("FAIL lw_beq_cnt got %h want 1", stall_cnt);
    end
    @(negedge clk);
    {E_A3, E_Reg_Write, E_Tnew} = '0;
    M_A3 = 5'd1; M_Reg_Write = 1'b1; M_Tnew = 4'd0;
    #1;
    vecs++;
    if (outs !== 12'b1_1_0_10_00_00_00_0) begin
      errs++; $display("FAIL lw_beq_fwd got %b want %b", outs, 12'b1_1_0_10_00_00_00_0);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    clear_inputs();
    E_Reg_Write = 1'b1; M_Reg_Write = 1'b1; W_Reg_Write = 1'b1;
    E_Tnew = 4'd3; M_Tnew = 4'd2;
    D_A1use = 1'b1; D_A2use = 1'b1;
    #1;
    vecs++;
    if (outs !== 12'b1_1_0_00_00_00_00_0) begin
      errs++; $display("FAIL zero_reg_busy got %b want %b", outs, 12'b1_1_0_00_00_00_00_0);
    end
    tick();
    @(negedge clk);
    E_Tnew = 4'd0; M_Tnew = 4'd0;
    #1;
    vecs++;
    if (outs !== 12'b1_1_0_00_00_00_00_0) begin
      errs++; $display("FAIL zero_reg_ready got %b want %b", outs, 12'b1_1_0_00_00_00_00_0);
    end
    tick();
  endtask

  task automatic test_div_busy();
    logic [31:0] base;
    int          busy_cycles;
    base = exp_cnt;
    busy_cycles = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      clear_inputs();
      E_md_start = (i == 0); E_md_div = (i == 0); D_is_md = 1'b1;
      #1;
      if (md_busy === 1'b1 && PC_en === 1'b0 && D_E_clear === 1'b1) busy_cycles++;
      tick();
    end
    vecs++;
    if (busy_cycles != 11) begin
      errs++; $display("FAIL div_busy_cycles got %0d want 11", busy_cycles);
    end
    @(negedge clk);
    #1;
    vecs++;
    if (outs !== 12'b1_1_0_00_00_00_00_0) begin
      errs++; $display("FAIL div_done got %b want %b", outs, 12'b1_1_0_00_00_00_00_0);
    end
    vecs++;
    if (stall_cnt !== base + 32'd11) begin
      errs++; $display("FAIL div_stall_cnt got %h want %h", stall_cnt, base + 32'd11);
    end
    tick();
  endtask

  task automatic test_random();
    logic [11:0] exp;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      D_A1 = 5'($urandom_range(0, 3)); D_A2 = 5'($urandom_range(0, 3));
      E_A1 = 5'($urandom_range(0, 3)); E_A2 = 5'($urandom_range(0, 3));
      E_A3 = 5'($urandom_range(0, 3)); M_A3 = 5'($urandom_range(0, 3));
      W_A3 = 5'($urandom_range(0, 3));
      D_A1use = 1'($urandom); D_A2use = 1'($urandom); D_is_md = 1'($urandom);
      E_Reg_Write = 1'($urandom); M_Reg_Write = 1'($urandom); W_Reg_Write = 1'($urandom);
      D_Tuse_rs = 2'($urandom); D_Tuse_rt = 2'($urandom);
      E_Tnew = 4'($urandom_range(0, 3)); M_Tnew = 4'($urandom_range(0, 2));
      E_md_start = ($urandom_range(0, 7) == 0); E_md_div = 1'($urandom);
      #1;
      exp = m_outs();
      vecs++;
      if (outs !== exp) begin
        errs++; $display("FAIL rand_outs[%0d] got %b want %b", i, outs, exp);
      end
      tick();
      vecs++;
      if (stall_cnt !== exp_cnt) begin
        errs++; $display("FAIL rand_cnt[%0d] got %h want %h", i, stall_cnt, exp_cnt);
      end
    end
    @(negedge clk);
    clear_inputs();
    for (int i = 0; i < 20 && cyc < md_end; i++) tick();
  endtask

  task automatic test_reset_mid_div();
    @(negedge clk);
    clear_inputs();
    E_md_start = 1'b1; E_md_div = 1'b1; D_is_md = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      E_md_start = 1'b0; E_md_div = 1'b0;
      tick();
    end
    @(negedge clk);
    D_is_md = 1'b0;
    #1;
    vecs++;
    if (md_busy !== 1'b1 || stall_cnt !== exp_cnt || exp_cnt == 32'd0) begin
      errs++; $display("FAIL pre_reset got busy=%b cnt=%h want busy=1 cnt=%h", md_busy, stall_cnt, exp_cnt);
    end
    reset = 1'b1;
    #1;
    exp_cnt = 32'd0;
    md_end = cyc;
    vecs++;
    if (outs !== 12'b1_1_0_00_00_00_00_0 || stall_cnt !== 32'd0) begin
      errs++; $display("FAIL async_reset got outs=%b cnt=%h want outs=%b cnt=0", outs, stall_cnt, 12'b1_1_0_00_00_00_00_0);
    end
    tick();
    @(negedge clk);
    reset = 1'b0;
    #1;
    vecs++;
    if (md_busy !== 1'b0) begin
      errs++; $display("FAIL post_reset_busy got %b want 0", md_busy);
    end
  endtask

  task automatic test_saturate();
    @(negedge clk);
    clear_inputs();
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    exp_cnt = 32'hFFFF_FFFE;
    #1;
    vecs++;
    if (stall_cnt !== 32'hFFFF_FFFE) begin
      errs++; $display("FAIL sat_preload got %h want fffffffe", stall_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      E_A3 = 5'd1; E_Reg_Write = 1'b1; E_Tnew = 4'd2;
      D_A1 = 5'd1; D_A1use = 1'b1; D_Tuse_rs = 2'd0;
      #1;
      vecs++;
      if (PC_en !== 1'b0) begin
        errs++; $display("FAIL sat_stall[%0d] got PC_en=%b want 0", i, PC_en);
      end
      tick();
      vecs++;
      if (stall_cnt !== 32'hFFFF_FFFF || exp_cnt !== 32'hFFFF_FFFF) begin
        errs++; $display("FAIL sat_hold[%0d] got %h want ffffffff", i, stall_cnt);
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    vecs = 0;
    errs = 0;
    cyc = 0;
    md_end = 0;
    exp_cnt = 32'd0;
    clear_inputs();
    test_reset();
    test_lw_use_no_stall();
    test_lw_branch_stall();
    test_zero_reg();
    test_div_busy();
    test_random();
    test_reset_mid_div();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
